sar_search_ctrl: RTL

//  Successive-approximation controller: the driving end of the n_bit_magnitude_comparator interface.

---
 rtl/sar_search_ctrl_if.sv | 64 ++++++
 rtl/sar_search_ctrl.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl_if.sv
// -----------------------------------------------------------------------------
// sar_search_ctrl_if
//   Bundle between the successive-approximation controller and its
//   surroundings: the requester (start / results) and the external magnitude
//   comparator (trial out, lt/gt/eq flags back).
//
//   Signals
//     start   requester  -> controller  request a new search
//     cmp_lt  comparator -> controller  trial <  target
//     cmp_gt  comparator -> controller  trial >  target
//     cmp_eq  comparator -> controller  trial == target
//     trial   controller -> comparator  word under test (comparator A input)
//     busy    controller -> requester   search in progress
//     done    controller -> requester   1-cycle pulse, result/steps updated
//     err     controller -> requester   1-cycle pulse, illegal flags, aborted
//     result  controller -> requester   last resolved value
//     steps   controller -> requester   compare cycles used by last search
//
//   Modports
//     master  the controller (drives trial and the status outputs)
//     slave   requester plus comparator side
// -----------------------------------------------------------------------------
interface sar_search_ctrl_if #(
    parameter int N = 10
);
    localparam int CNT_W = $clog2(N + 1);

    logic             start;
    logic             cmp_lt;
    logic             cmp_gt;
    logic             cmp_eq;
    logic [N-1:0]     trial;
    logic             busy;
    logic             done;
    logic             err;
    logic [N-1:0]     result;
    logic [CNT_W-1:0] steps;

    modport master (
        input  start,
        input  cmp_lt,
        input  cmp_gt,
        input  cmp_eq,
        output trial,
        output busy,
        output done,
        output err,
        output result,
        output steps
    );

    modport slave (
        output start,
        output cmp_lt,
        output cmp_gt,
        output cmp_eq,
        input  trial,
        input  busy,
        input  done,
        input  err,
        input  result,
        input  steps
    );
endinterface

// File: rtl/sar_search_ctrl.sv
// -----------------------------------------------------------------------------
// sar_search_ctrl
//   Successive-approximation search controller. Drives trial words into an
//   external combinational magnitude comparator (target on its B input) and
//   resolves, MSB first, the largest value <= target in at most N compares.
//   An exact match ends the search early. Usable as a threshold finder or as
//   the digital core of a SAR ADC.
//
//   Ports
//     clk     rising-edge clock
//     rst_n   asynchronous active-low reset
//     bus     sar_search_ctrl_if.master
//               start in; cmp_lt/cmp_gt/cmp_eq in;
//               trial, busy, done, err, result, steps out (all registered)
//
//   Parameter
//     N       trial/result width, N >= 2 (must match the interface N)
// -----------------------------------------------------------------------------
module sar_search_ctrl #(
    parameter int N = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    sar_search_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(N + 1);
    localparam int IDX_W = $clog2(N);

    localparam logic [N-1:0]     TRIAL_MSB = {1'b1, {(N-1){1'b0}}};
    localparam logic [N-1:0]     ONE_N     = {{(N-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        TEST = 1'b1
    } state_t;

    state_t           state_reg;
    logic [N-1:0]     trial_reg;
    logic [IDX_W-1:0] bit_idx_reg;
    logic [CNT_W-1:0] count_reg;
    logic [N-1:0]     result_reg;
    logic [CNT_W-1:0] steps_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             err_reg;

    // Datapath helpers for the current compare step.
    logic             flags_onehot;
    logic [N-1:0]     bit_mask;
    logic [N-1:0]     trial_adj;
    logic [N-1:0]     trial_next;

    always_comb begin
        flags_onehot = 1'b0;
        bit_mask     = '0;
        trial_adj    = '0;
        trial_next   = '0;

        // XOR is 1 for one or three flags high; the AND term rejects three.
        flags_onehot = (bus.cmp_lt ^ bus.cmp_gt ^ bus.cmp_eq)
                     & ~(bus.cmp_lt & bus.cmp_gt & bus.cmp_eq);

        bit_mask = ONE_N << bit_idx_reg;

        // Trial too large: drop the bit under test; otherwise keep it.
        trial_adj = bus.cmp_gt ? (trial_reg & ~bit_mask) : trial_reg;

        // Tentatively set the next lower bit. Only used when bit_idx > 0, so
        // the shift never falls off the bottom and trial stays below 2^N.
        trial_next = trial_adj | (bit_mask >> 1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            trial_reg   <= '0;
            bit_idx_reg <= IDX_TOP;
            count_reg   <= '0;
            result_reg  <= '0;
            steps_reg   <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            // Status pulses last exactly one cycle.
            done_reg <= 1'b0;
            err_reg  <= 1'b0;

            case (state_reg)
                IDLE: begin
                    trial_reg <= '0;
                    busy_reg  <= 1'b0;
                    // done_reg high means this is the cycle the previous
                    // search finished; a start here is deliberately dropped.
                    if (bus.start && !done_reg) begin
                        state_reg   <= TEST;
                        trial_reg   <= TRIAL_MSB;
                        bit_idx_reg <= IDX_TOP;
                        count_reg   <= CNT_ONE;
                        busy_reg    <= 1'b1;
                    end
                end

                TEST: begin
                    if (!flags_onehot) begin
                        // Broken comparator response: abort, keep old result.
                        err_reg     <= 1'b1;
                        state_reg   <= IDLE;
                        trial_reg   <= '0;
                        bit_idx_reg <= IDX_TOP;
                        busy_reg    <= 1'b0;
                    end else if (bus.cmp_eq) begin
                        // Exact hit: no lower bit can improve the answer.
                        result_reg  <= trial_reg;
                        steps_reg   <= count_reg;
                        done_reg    <= 1'b1;
                        state_reg   <= IDLE;
                        trial_reg   <= '0;
                        bit_idx_reg <= IDX_TOP;
                        busy_reg    <= 1'b0;
                    end else if (bit_idx_reg == '0) begin
                        result_reg  <= trial_adj;
                        steps_reg   <= count_reg;
                        done_reg    <= 1'b1;
                        state_reg   <= IDLE;
                        trial_reg   <= '0;
                        bit_idx_reg <= IDX_TOP;
                        busy_reg    <= 1'b0;
                    end else begin
                        trial_reg   <= trial_next;
                        bit_idx_reg <= bit_idx_reg - 1'b1;
                        count_reg   <= count_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                    trial_reg <= '0;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.trial  = trial_reg;
    assign bus.busy   = busy_reg;
    assign bus.done   = done_reg;
    assign bus.err    = err_reg;
    assign bus.result = result_reg;
    assign bus.steps  = steps_reg;

endmodule
